// File: rtl/regfile_pkg.sv
// Shared constants and FSM state type for the multiport register file.
package regfile_pkg;
  localparam int RF_WIDTH = 32;
  localparam int RF_DEPTH = 32;

  typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_t;
endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: walks every entry once after reset or on clr_req, one per cycle.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int  DEPTH  = RF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  rf_state_t         state_q;
  logic [ADDR_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RF_CLEAR;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        RF_IDLE: begin
          if (clr_req) begin
            state_q <= RF_CLEAR;
            cnt_q   <= '0;
          end
        end
        RF_CLEAR: begin
          // clr_req is ignored here so a running clear is never stretched
          if (cnt_q == LAST) begin
            state_q <= RF_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= RF_CLEAR;
      endcase
    end
  end

  assign busy     = (state_q == RF_CLEAR);
  assign clr_we   = busy && !reset;
  assign clr_addr = cnt_q;

endmodule

// File: rtl/regfile_multiport_clr.sv
// Two-read/one-write register file with optional zero register and sequenced clear.
// Optional write-first forwarding on the read ports: define REGFILE_BYPASS_EN.
module regfile_multiport_clr
  import regfile_pkg::*;
#(
  parameter int  WIDTH    = RF_WIDTH,
  parameter int  DEPTH    = RF_DEPTH,
  parameter int  ZERO_REG = 1,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_req,
  output logic              busy,
  input  logic [ADDR_W-1:0] read_address_0,
  input  logic [ADDR_W-1:0] read_address_1,
  output logic [WIDTH-1:0]  read_data_0,
  output logic [WIDTH-1:0]  read_data_1,
  input  logic [ADDR_W-1:0] write_address_0,
  input  logic              write_en,
  input  logic [WIDTH-1:0]  write_data
);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_ok;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (int'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  regfile_clear_seq #(.DEPTH(DEPTH)) u_clr (
    .clk      (clk),
    .reset    (reset),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // clr_req wins over a same-cycle write
  assign wr_ok = write_en && !busy && !clr_req && addr_ok(write_address_0);

  always_ff @(posedge clk) begin
    if (clr_we)
      mem_q[clr_addr] <= '0;
    else if (wr_ok)
      mem_q[write_address_0] <= write_data;
  end

  logic [ADDR_W-1:0] ra [2];
  logic [WIDTH-1:0]  rd [2];

  assign ra[0] = read_address_0;
  assign ra[1] = read_address_1;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    always_comb begin
      rd[p] = '0;
      if (!busy && addr_ok(ra[p])) begin
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (ra[p] == write_address_0))
          rd[p] = write_data;
        else
          rd[p] = mem_q[ra[p]];
`else
        rd[p] = mem_q[ra[p]];
`endif
      end
    end
  end

  assign read_data_0 = rd[0];
  assign read_data_1 = rd[1];

endmodule

// File: tb/tb_regfile_multiport_clr.sv
// Bench: default instance (32 deep, zero reg) plus a 24-deep instance without zero reg,
// both compared each cycle against a behavioural model.
module tb_regfile_multiport_clr;
  logic        clk = 1'b0;
  logic        reset, clr_req, we;
  logic [4:0]  ra0, ra1, wa;
  logic [31:0] wd;
  logic        busy_a, busy_b;
  logic [31:0] rd0_a, rd1_a, rd0_b, rd1_b;

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  logic [31:0] m [2][32];
  int          bl [2];

  always #5 clk = ~clk;

  regfile_multiport_clr u_dut (
    .clk(clk), .reset(reset), .clr_req(clr_req), .busy(busy_a),
    .read_address_0(ra0), .read_address_1(ra1),
    .read_data_0(rd0_a), .read_data_1(rd1_a),
    .write_address_0(wa), .write_en(we), .write_data(wd));

  regfile_multiport_clr #(.WIDTH(32), .DEPTH(24), .ZERO_REG(0)) u_dut24 (
    .clk(clk), .reset(reset), .clr_req(clr_req), .busy(busy_b),
    .read_address_0(ra0), .read_address_1(ra1),
    .read_data_0(rd0_b), .read_data_1(rd1_b),
    .write_address_0(wa), .write_en(we), .write_data(wd));

  function automatic int dep(int i);
    return (i == 0) ? 32 : 24;
  endfunction

  function automatic bit zr(int i);
    return i == 0;
  endfunction

  function automatic bit acc(int i);
    return bl[i] == 0 && !clr_req && we && int'(wa) < dep(i) && !(zr(i) && wa == 0);
  endfunction

  function automatic logic [31:0] exp_rd(int i, logic [4:0] a);
    if (bl[i] > 0) return 32'h0;
    if (int'(a) >= dep(i)) return 32'h0;
    if (zr(i) && a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (acc(i) && a == wa) return wd;
`endif
    return m[i][a];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_clear(input int i);
    bl[i] = dep(i);
    for (int k = 0; k < 32; k++) m[i][k] = 32'h0;
  endtask

  // One clock: check outputs before the edge, then advance the model at the edge.
  task automatic cycle();
    bit a0, a1;
    #1;
    if (chk_en) begin
      check("busy_a", {31'b0, busy_a}, {31'b0, bl[0] > 0});
      check("busy_b", {31'b0, busy_b}, {31'b0, bl[1] > 0});
      check("rd0_a", rd0_a, exp_rd(0, ra0));
      check("rd1_a", rd1_a, exp_rd(0, ra1));
      check("rd0_b", rd0_b, exp_rd(1, ra0));
      check("rd1_b", rd1_b, exp_rd(1, ra1));
    end
    a0 = acc(0);
    a1 = acc(1);
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (reset) start_clear(i);
      else if (bl[i] > 0) bl[i]--;
      else if (clr_req) start_clear(i);
      else if ((i == 0) ? a0 : a1) m[i][wa] = wd;
    end
    if (reset) chk_en = 1;
    @(negedge clk);
  endtask

  task automatic quiet();
    reset = 0; clr_req = 0; we = 0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int k = 0; k < 60; k++) begin
      if (busy_a) n++;
      cycle();
    end
  endtask

  initial begin
    int n;
    reset = 1; clr_req = 0; we = 0; ra0 = 5; ra1 = 5; wa = 0; wd = 0;

    // 1: reset held 3 cycles, busy exactly DEPTH cycles, reads 0 throughout
    repeat (3) cycle();
    reset = 0;
    check("t1_rd_during", rd0_a, 32'h0);
    count_busy(n);
    check("t1_busy_len", n, 32);
    check("t1_rd_after", rd0_a, 32'h0);

    // 2: basic write then read
    we = 1; wa = 2; wd = 32'h87654321; cycle();
    we = 0; ra0 = 2; ra1 = 3; #1;
    check("t2_rd0", rd0_a, 32'h87654321);
    check("t2_rd1", rd1_a, 32'h0);
    cycle();

    // 3: entry 0 hardwired on ZERO_REG=1, ordinary on ZERO_REG=0
    we = 1; wa = 0; wd = 32'hABCDEF01; cycle();
    we = 0; ra0 = 0; ra1 = 0; #1;
    check("t3_z_rd0", rd0_a, 32'h0);
    check("t3_z_rd1", rd1_a, 32'h0);
    check("t3_nz_rd0", rd0_b, 32'hABCDEF01);
    check("t3_nz_rd1", rd1_b, 32'hABCDEF01);
    cycle();

    // 4: read-during-write on the same address
    we = 1; wa = 3; wd = 32'h12345678; ra1 = 3; #1;
`ifdef REGFILE_BYPASS_EN
    check("t4_same", rd1_a, 32'h12345678);
`else
    check("t4_same", rd1_a, 32'h0);
`endif
    cycle();
    we = 0; #1;
    check("t4_next", rd1_a, 32'h12345678);
    cycle();

    // 5: clr_req clears everything, write during busy dropped
    clr_req = 1; cycle();
    clr_req = 0;
    we = 1; wa = 4; wd = 32'hDEADBEEF; cycle();
    we = 0;
    count_busy(n);
    check("t5_busy_len", n, 31);
    for (int a = 2; a <= 4; a++) begin
      ra0 = 5'(a); #1;
      check("t5_cleared", rd0_a, 32'h0);
      cycle();
    end

    // 6: reset at clr_cnt=10 restarts the clear; clr_req mid-clear is ignored
    we = 1; wa = 7; wd = 32'h0BADF00D; cycle();
    quiet();
    clr_req = 1; cycle();
    clr_req = 0;
    repeat (10) cycle();
    reset = 1; cycle();
    check("t6_busy_rst", {31'b0, busy_a}, 32'h1);
    reset = 0;
    n = 0;
    for (int k = 0; k < 60; k++) begin
      if (busy_a) n++;
      clr_req = (k == 5);
      cycle();
    end
    clr_req = 0;
    check("t6_busy_len", n, 32);

    // Random traffic against the model
    for (int k = 0; k < 600; k++) begin
      reset   = ($urandom_range(199) == 0);
      clr_req = ($urandom_range(39) == 0);
      we      = ($urandom_range(2) != 0);
      wa      = 5'($urandom_range(31));
      wd      = $urandom;
      ra0     = ($urandom_range(3) == 0) ? wa : 5'($urandom_range(31));
      ra1     = ($urandom_range(3) == 0) ? wa : 5'($urandom_range(31));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/regfile_multiport_clr.md
Name: regfile_multiport_clr

Overview:
- Parametrised successor to the CPU register file: configurable data width and depth, with a two-read/one-write port set.
- Adds a synchronous clock, a hardwired-zero register option and a sequenced clear engine.
- The clear engine zeroes every entry after reset or on request, one entry per cycle, and signals busy meanwhile.
- Sits between decode (read addresses) and writeback (write port) in the multicycle datapath.

Parameters:
WIDTH, 32, data width of each register in bits
DEPTH, 32, number of registers (>=2; need not be a power of two)
ZERO_REG, 1, 1 = entry 0 reads as zero and ignores writes; 0 = entry 0 is an ordinary register
ADDR_W (localparam), $clog2(DEPTH), address width of all address ports

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
clr_req  input  1  single-cycle request to start a full clear
busy  output  1  high while the clear sequence runs
read_address_0  input  ADDR_W  read port 0 address
read_address_1  input  ADDR_W  read port 1 address
read_data_0  output  WIDTH  read port 0 data
read_data_1  output  WIDTH  read port 1 data
write_address_0  input  ADDR_W  write address
write_en  input  1  write strobe
write_data  input  WIDTH  data to write

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high on `reset`.
- FSM states: IDLE, CLEAR. Clear counter clr_cnt is ADDR_W bits.
- Reset: at a rising edge with reset=1, state<=CLEAR and clr_cnt<=0.
  - Held reset keeps state=CLEAR, clr_cnt=0.
  - Reset mid-clear restarts the clear from 0.
- CLEAR, each cycle without reset: mem[clr_cnt]<=0 and clr_cnt++.
  - When clr_cnt==DEPTH-1, the last entry is cleared and state<=IDLE.
  - After reset deasserts, busy stays high for exactly DEPTH cycles.
- IDLE with clr_req=1: state<=CLEAR, clr_cnt<=0.
  - A write presented in the same cycle is dropped (clear has priority).
  - clr_req in CLEAR is ignored; it does not restart the sequence.
- busy = (state==CLEAR), combinational from the state register. Its value after the first reset edge is 1.
- Write: in IDLE with write_en=1 and no clr_req, mem[write_address_0]<=write_data at the rising edge.
  - Ignored when write_address_0>=DEPTH.
  - Ignored when address==0 and ZERO_REG=1.
  - Writes with busy=1 are dropped silently.
- Reads: combinational, with this priority:
  - busy=1: read_data = 0.
  - Else address>=DEPTH: 0.
  - Else address==0 with ZERO_REG=1: 0.
  - Else mem[address] (subject to the optional bypass).
- Both read ports are independent; the same address on both returns identical data.
- Read-during-write to the same address without bypass returns the old value; the new value is visible from the next cycle.
- No X on outputs after the first reset edge. Memory contents before the clear completes are don't-care but are never visible, because reads are forced to 0 while busy.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a read port whose address equals write_address_0 while a write is accepted that cycle returns write_data combinationally (write-first forwarding).
  - Forwarding does not apply to entry 0 when ZERO_REG=1.
  - Forwarding does not apply when the write is dropped (busy, clr_req, or out of range).
- Undefined: read-first; the old value is returned and the new value is visible next cycle.

Decomposition:
- Package regfile_pkg holds:
  - default constants RF_WIDTH=32 and RF_DEPTH=32;
  - the state enum rf_state_t {RF_IDLE, RF_CLEAR}.
- One sub-module, regfile_clear_seq:
  - contains the FSM and clr_cnt;
  - inputs: reset, clr_req;
  - outputs: busy, clr_we, clr_addr.
- The storage array, write-enable mux and read muxes stay in the top module.

Test Plan:
1. Reset held 3 cycles, then released: busy=1 for exactly 32 cycles and then 0. read_address_0=5 returns 0 both during and after the clear. No X on any output.
2. After the clear, write 32'h87654321 to address 2. Next cycle, read_address_0=2 returns 32'h87654321 and read_address_1=3 returns 0.
3. ZERO_REG=1: write 32'hABCDEF01 to address 0, then read address 0 on both ports: 0. Repeat with ZERO_REG=0: returns 32'hABCDEF01.
4. Write 32'h12345678 to address 3 while read_address_1=3 in the same cycle:
   - with REGFILE_BYPASS_EN: 32'h12345678 that cycle;
   - without it: 0 that cycle and 32'h12345678 the next.
5. With addresses 2 and 3 written, pulse clr_req:
   - busy=1 for 32 cycles;
   - write_en to address 4 with 32'hDEADBEEF during busy is dropped;
   - afterwards addresses 2, 3 and 4 all read 0.
6. During a clear, assert reset at clr_cnt=10 for 1 cycle: busy stays high, the clear restarts, and busy falls exactly 32 cycles after reset deasserts. A clr_req mid-clear does not extend busy.
